sound_latch_bridge: RTL and testbench

- 68000-to-Z80 sound command bridge for the NextSpace core.
- Sits directly downstream of the address decoder and consumes its 68000 latch write select (0x0f0009), 68000 sound status read select (0x0e0018) and Z80 latch select (0xf800).
- Captures one command byte per 68000 write and raises a timed NMI to the Z80.
- Holds the byte until the Z80 acknowledges it, and reports pending/overrun status back to the 68000.

---
 rtl/sound_latch_bridge.sv | 172 +++++++++++++++++
 tb/tb_sound_latch_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_latch_bridge.sv
// 68000-to-Z80 sound command bridge: one-byte command latch, timed Z80 NMI and pending/overrun status.
// Define SOUND_LATCH_FIFO_EN to replace the single latch with a FIFO_DEPTH-entry command queue.
module sound_latch_bridge #(
  parameter int unsigned NMI_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_latch_cs,
  input  logic        m68k_sound_cs,
  input  logic [7:0]  m68k_din,
  output logic [15:0] m68k_dout,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  output logic [7:0]  z80_dout,
  output logic        z80_nmi_n,
  output logic        pending
);

  if (NMI_WIDTH < 1 || NMI_WIDTH > 255) begin : gen_bad_nmi_width
    $error("NMI_WIDTH must be in 1..255");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end

  // Z80 reads are non-destructive, so the read strobe carries no state.
  logic unused_z80_rd_n;
  assign unused_z80_rd_n = z80_rd_n;

  // Rising-edge detection of the long-lived selects
  logic push_hist_q, clr_hist_q, sts_hist_q;
  logic clr_sel;
  logic push, clr, sts;

  assign clr_sel = z80_latch_cs & ~z80_wr_n;
  assign push    = m68k_latch_cs & ~push_hist_q;
  assign clr     = clr_sel & ~clr_hist_q;
  assign sts     = m68k_sound_cs & ~sts_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      push_hist_q <= 1'b0;
      clr_hist_q  <= 1'b0;
      sts_hist_q  <= 1'b0;
    end else begin
      push_hist_q <= m68k_latch_cs;
      clr_hist_q  <= clr_sel;
      sts_hist_q  <= m68k_sound_cs;
    end
  end

  logic overrun_q, overrun_d;
  logic overrun_set;
  logic nmi_load;
  logic [7:0] nmi_cnt_q, nmi_cnt_d;
  logic [15:0] m68k_dout_q;

`ifdef SOUND_LATCH_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            empty, full, do_enq, do_deq;
  logic            renmi_q;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    do_deq  = clr & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    do_enq  = push & (~full | do_deq);
    count_d = count_q;
    if (do_enq && !do_deq) begin
      count_d = count_q + 1'b1;
    end else if (do_deq && !do_enq) begin
      count_d = count_q - 1'b1;
    end
    overrun_set = push & ~do_enq;
    nmi_load    = do_enq | renmi_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      renmi_q  <= 1'b0;
    end else begin
      if (do_enq) begin
        mem_q[wr_ptr_q] <= m68k_din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      // Re-signal the Z80 when commands remain after an acknowledge.
      renmi_q <= do_deq & (count_d != '0);
    end
  end

  assign pending  = ~empty;
  assign z80_dout = empty ? 8'h00 : mem_q[rd_ptr_q];
`else
  logic [7:0] latch_q;
  logic       pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (push) begin
      pending_d = 1'b1;
    end else if (clr) begin
      pending_d = 1'b0;
    end
    overrun_set = push & pending_q & ~clr;
    nmi_load    = push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q   <= 8'h00;
      pending_q <= 1'b0;
    end else begin
      if (push) begin
        latch_q <= m68k_din;
      end
      pending_q <= pending_d;
    end
  end

  assign pending  = pending_q;
  assign z80_dout = latch_q;
`endif

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (sts) begin
      overrun_d = 1'b0;
    end
    nmi_cnt_d = nmi_cnt_q;
    if (nmi_load) begin
      nmi_cnt_d = 8'(NMI_WIDTH);
    end else if (nmi_cnt_q != 8'h00) begin
      nmi_cnt_d = nmi_cnt_q - 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      nmi_cnt_q   <= 8'h00;
      m68k_dout_q <= 16'h0000;
    end else begin
      overrun_q   <= overrun_d;
      nmi_cnt_q   <= nmi_cnt_d;
      // Status lags state by one cycle, so a status read still sees the overrun it clears.
      m68k_dout_q <= {14'b0, overrun_q, pending};
    end
  end

  assign m68k_dout = m68k_dout_q;
  assign z80_nmi_n = (nmi_cnt_q == 8'h00);

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Directed self-checking bench for sound_latch_bridge (default NMI_WIDTH = 16, FIFO_DEPTH = 4).
module tb_sound_latch_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m68k_latch_cs = 1'b0;
  logic        m68k_sound_cs = 1'b0;
  logic [7:0]  m68k_din = 8'h00;
  logic [15:0] m68k_dout;
  logic        z80_latch_cs = 1'b0;
  logic        z80_rd_n = 1'b1;
  logic        z80_wr_n = 1'b1;
  logic [7:0]  z80_dout;
  logic        z80_nmi_n;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  sound_latch_bridge #(
    .NMI_WIDTH (16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m68k_latch_cs(m68k_latch_cs),
    .m68k_sound_cs(m68k_sound_cs),
    .m68k_din     (m68k_din),
    .m68k_dout    (m68k_dout),
    .z80_latch_cs (z80_latch_cs),
    .z80_rd_n     (z80_rd_n),
    .z80_wr_n     (z80_wr_n),
    .z80_dout     (z80_dout),
    .z80_nmi_n    (z80_nmi_n),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (z80_nmi_n !== 1'b1) begin
      n_bad++; $display("FAIL reset_nmi: got %b want 1", z80_nmi_n);
    end
    n_cmp++;
    if (pending !== 1'b0) begin
      n_bad++; $display("FAIL reset_pending: got %b want 0", pending);
    end
    n_cmp++;
    if (z80_dout !== 8'h00) begin
      n_bad++; $display("FAIL reset_z80_dout: got %h want 00", z80_dout);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (m68k_dout !== 16'h0000) begin
      n_bad++; $display("FAIL reset_m68k_dout: got %h want 0000", m68k_dout);
    end
  endtask

  task automatic test_push();
    int lows;
    m68k_din = 8'h5A;
    m68k_latch_cs = 1'b1;
    tick();
    n_cmp++;
    if (pending !== 1'b1 || z80_dout !== 8'h5A || z80_nmi_n !== 1'b0) begin
      n_bad++;
      $display("FAIL push_edge: got pend=%b dout=%h nmi_n=%b want 1 5a 0", pending, z80_dout,
               z80_nmi_n);
    end
    lows = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) m68k_latch_cs = 1'b0;
      tick();
      if (!z80_nmi_n) lows++;
    end
    n_cmp++;
    if (lows !== 16) begin
      n_bad++; $display("FAIL push_nmi_width: got %0d cycles want 16", lows);
    end
    n_cmp++;
    if (m68k_dout !== 16'h0001) begin
      n_bad++; $display("FAIL push_status: got %h want 0001", m68k_dout);
    end
  endtask

  task automatic test_z80_access();
    for (int i = 0; i < 3; i++) begin
      z80_latch_cs = 1'b1;
      z80_rd_n = 1'b0;
      tick();
      n_cmp++;
      if (z80_dout !== 8'h5A || pending !== 1'b1) begin
        n_bad++;
        $display("FAIL z80_read%0d: got dout=%h pend=%b want 5a 1", i, z80_dout, pending);
      end
      z80_latch_cs = 1'b0;
      z80_rd_n = 1'b1;
      tick();
    end
    z80_latch_cs = 1'b1;
    z80_wr_n = 1'b0;
    tick();
    n_cmp++;
    if (pending !== 1'b0 || z80_dout !== 8'h5A) begin
      n_bad++; $display("FAIL z80_clr: got pend=%b dout=%h want 0 5a", pending, z80_dout);
    end
    z80_latch_cs = 1'b0;
    z80_wr_n = 1'b1;
    tick();
    n_cmp++;
    if (m68k_dout !== 16'h0000) begin
      n_bad++; $display("FAIL clr_status: got %h want 0000", m68k_dout);
    end
  endtask

  task automatic test_overrun();
    m68k_din = 8'h11; m68k_latch_cs = 1'b1; tick();
    m68k_latch_cs = 1'b0; tick();
    m68k_din = 8'h22; m68k_latch_cs = 1'b1; tick();
    m68k_latch_cs = 1'b0; tick();
    n_cmp++;
    if (z80_dout !== 8'h22) begin
      n_bad++; $display("FAIL overrun_data: got %h want 22", z80_dout);
    end
    n_cmp++;
    if (m68k_dout !== 16'h0003) begin
      n_bad++; $display("FAIL overrun_status: got %h want 0003", m68k_dout);
    end
    m68k_sound_cs = 1'b1; tick();
    n_cmp++;
    if (m68k_dout !== 16'h0003) begin
      n_bad++; $display("FAIL sts_read1: got %h want 0003", m68k_dout);
    end
    tick();
    m68k_sound_cs = 1'b0; tick();
    m68k_sound_cs = 1'b1; tick();
    n_cmp++;
    if (m68k_dout !== 16'h0001) begin
      n_bad++; $display("FAIL sts_read2: got %h want 0001", m68k_dout);
    end
    m68k_sound_cs = 1'b0;
    z80_latch_cs = 1'b1; z80_wr_n = 1'b0; tick();
    z80_latch_cs = 1'b0; z80_wr_n = 1'b1; tick();
  endtask

  task automatic test_push_clr_same_cycle();
    m68k_din = 8'hAA; m68k_latch_cs = 1'b1; tick();
    m68k_latch_cs = 1'b0; tick();
    m68k_din = 8'h33; m68k_latch_cs = 1'b1;
    z80_latch_cs = 1'b1; z80_wr_n = 1'b0;
    tick();
    n_cmp++;
    if (pending !== 1'b1 || z80_dout !== 8'h33) begin
      n_bad++; $display("FAIL push_clr: got pend=%b dout=%h want 1 33", pending, z80_dout);
    end
    m68k_latch_cs = 1'b0; z80_latch_cs = 1'b0; z80_wr_n = 1'b1;
    tick();
    n_cmp++;
    if (m68k_dout !== 16'h0001) begin
      n_bad++; $display("FAIL push_clr_status: got %h want 0001", m68k_dout);
    end
  endtask

  task automatic test_reset_mid_nmi();
    m68k_din = 8'h44; m68k_latch_cs = 1'b1; tick();
    m68k_latch_cs = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (z80_nmi_n !== 1'b0) begin
      n_bad++; $display("FAIL mid_nmi_active: got %b want 0", z80_nmi_n);
    end
    reset = 1'b1; tick();
    n_cmp++;
    if (z80_nmi_n !== 1'b1 || pending !== 1'b0 || z80_dout !== 8'h00 || m68k_dout !== 16'h0000)
    begin
      n_bad++;
      $display("FAIL mid_nmi_reset: got nmi_n=%b pend=%b z80=%h m68k=%h want 1 0 00 0000",
               z80_nmi_n, pending, z80_dout, m68k_dout);
    end
    reset = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    int lows;
    int rises;
    logic prev;
    m68k_din = 8'h55; m68k_latch_cs = 1'b1; tick();
    m68k_latch_cs = 1'b0;
    lows = (z80_nmi_n == 1'b0) ? 1 : 0;
    rises = 0;
    prev = z80_nmi_n;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        m68k_din = 8'h66; m68k_latch_cs = 1'b1;
      end else begin
        m68k_latch_cs = 1'b0;
      end
      tick();
      if (!z80_nmi_n) lows++;
      if (z80_nmi_n && !prev) rises++;
      prev = z80_nmi_n;
    end
    n_cmp++;
    if (lows !== 22 || rises !== 1) begin
      n_bad++; $display("FAIL nmi_extend: got %0d low %0d rises want 22 1", lows, rises);
    end
    n_cmp++;
    if (z80_dout !== 8'h66 || m68k_dout !== 16'h0003) begin
      n_bad++; $display("FAIL b2b_state: got %h %h want 66 0003", z80_dout, m68k_dout);
    end
  endtask

`ifdef SOUND_LATCH_FIFO_EN
  task automatic test_fifo();
    for (int i = 1; i <= 5; i++) begin
      m68k_din = 8'(i); m68k_latch_cs = 1'b1; tick();
      m68k_latch_cs = 1'b0; tick();
    end
    n_cmp++;
    if (m68k_dout !== 16'h0003) begin
      n_bad++; $display("FAIL fifo_overrun: got %h want 0003", m68k_dout);
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (z80_dout !== 8'(i) || pending !== 1'b1) begin
        n_bad++; $display("FAIL fifo_head%0d: got %h pend=%b want %h 1", i, z80_dout, pending, i);
      end
      z80_latch_cs = 1'b1; z80_wr_n = 1'b0; tick();
      z80_latch_cs = 1'b0; z80_wr_n = 1'b1; tick();
    end
    n_cmp++;
    if (pending !== 1'b0 || z80_dout !== 8'h00) begin
      n_bad++; $display("FAIL fifo_empty: got pend=%b dout=%h want 0 00", pending, z80_dout);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SOUND_LATCH_FIFO_EN
    test_fifo();
`else
    test_push();
    test_z80_access();
    test_overrun();
    test_push_clr_same_cycle();
    test_reset_mid_nmi();
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
